// File: rtl/trace_event_collector.sv
// rtl/trace_event_collector.sv - per-core trace decode, character FIFOs, round-robin output, termination and watchdog
module trace_event_collector #(
  parameter int NUM_CORES      = 9,
  parameter int FIFO_DEPTH     = 8,
  parameter int TIMEOUT_CYCLES = 1000000,
  localparam int CW            = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [NUM_CORES-1:0]    trace_valid,
  input  logic [32*NUM_CORES-1:0] trace_insn,
  input  logic [32*NUM_CORES-1:0] trace_r3,
  output logic                    char_valid,
  input  logic                    char_ready,
  output logic [7:0]              char_data,
  output logic [CW-1:0]           char_core,
  output logic [NUM_CORES-1:0]    term_mask,
  output logic [32*NUM_CORES-1:0] exit_code,
  output logic                    all_done,
  output logic                    timeout,
  output logic [NUM_CORES-1:0]    overflow
);

  localparam int          AW        = $clog2(FIFO_DEPTH);
  localparam logic [31:0] INSN_TERM = 32'h1500_0001;
  localparam logic [31:0] INSN_PUTC = 32'h1500_0004;
  localparam logic [31:0] WD_LIMIT  = 32'(TIMEOUT_CYCLES);
  localparam logic        WD_ENABLE = (TIMEOUT_CYCLES != 0);

  typedef logic [AW:0] ptr_t;

  logic [NUM_CORES-1:0] live_ev, term_ev, putc_ev;
  logic [NUM_CORES-1:0] fifo_empty, fifo_full, push, pop;

  ptr_t wr_ptr_q [NUM_CORES];
  ptr_t wr_ptr_d [NUM_CORES];
  ptr_t rd_ptr_q [NUM_CORES];
  ptr_t rd_ptr_d [NUM_CORES];
  logic [7:0] mem_q [NUM_CORES][FIFO_DEPTH];

  logic                    char_valid_q, char_valid_d;
  logic [7:0]              char_data_q, char_data_d;
  logic [CW-1:0]           char_core_q, char_core_d;
  logic [CW-1:0]           rr_q, rr_d;
  logic [NUM_CORES-1:0]    term_mask_q, term_mask_d;
  logic [NUM_CORES-1:0]    overflow_q, overflow_d;
  logic [32*NUM_CORES-1:0] exit_code_q, exit_code_d;
  logic                    all_done_q, all_done_d;
  logic                    timeout_q, timeout_d;
  logic [31:0]             wd_q, wd_d;

  logic          found;
  logic          load_en;
  logic [CW-1:0] grant;
  logic [7:0]    rd_data;

  // Once a core has terminated, nothing it retires is seen, not even by the watchdog.
  always_comb begin
    for (int i = 0; i < NUM_CORES; i++) begin
      live_ev[i]    = trace_valid[i] & ~term_mask_q[i];
      term_ev[i]    = live_ev[i] & (trace_insn[32*i +: 32] == INSN_TERM);
      putc_ev[i]    = live_ev[i] & (trace_insn[32*i +: 32] == INSN_PUTC);
      fifo_empty[i] = (wr_ptr_q[i] == rd_ptr_q[i]);
      fifo_full[i]  = (wr_ptr_q[i][AW] != rd_ptr_q[i][AW]) &&
                      (wr_ptr_q[i][AW-1:0] == rd_ptr_q[i][AW-1:0]);
    end
  end

  always_comb begin
    int idx;
    found = 1'b0;
    grant = '0;
    idx   = 0;
    for (int k = 0; k < NUM_CORES; k++) begin
      idx = int'(rr_q) + k;
      if (idx >= NUM_CORES) idx = idx - NUM_CORES;
      if (!found && !fifo_empty[CW'(idx)]) begin
        found = 1'b1;
        grant = CW'(idx);
      end
    end
  end

  assign load_en = ~char_valid_q | char_ready;
  assign rd_data = mem_q[grant][rd_ptr_q[grant][AW-1:0]];

  always_comb begin
    char_valid_d = char_valid_q;
    char_data_d  = char_data_q;
    char_core_d  = char_core_q;
    rr_d         = rr_q;
    term_mask_d  = term_mask_q | term_ev;
    overflow_d   = overflow_q;
    exit_code_d  = exit_code_q;
    all_done_d   = all_done_q | ((&term_mask_q) & (&fifo_empty) & ~char_valid_q);
    wd_d         = wd_q;
    timeout_d    = timeout_q;

    // A pop in the same cycle frees the slot, so a full FIFO can still take a push.
    for (int i = 0; i < NUM_CORES; i++) begin
      pop[i]  = load_en & found & (grant == CW'(i));
      push[i] = putc_ev[i] & (~fifo_full[i] | pop[i]);
      if (putc_ev[i] & fifo_full[i] & ~pop[i]) overflow_d[i] = 1'b1;
      if (term_ev[i]) exit_code_d[32*i +: 32] = trace_r3[32*i +: 32];
      wr_ptr_d[i] = wr_ptr_q[i] + ptr_t'(push[i]);
      rd_ptr_d[i] = rd_ptr_q[i] + ptr_t'(pop[i]);
    end

    if (load_en) begin
      char_valid_d = found;
      if (found) begin
        char_data_d = rd_data;
        char_core_d = grant;
        rr_d        = (grant == CW'(NUM_CORES - 1)) ? '0 : grant + 1'b1;
      end
    end

    if (WD_ENABLE && !all_done_q) begin
      if (|live_ev) wd_d = '0;
      else if (wd_q != '1) wd_d = wd_q + 32'd1;
      if (wd_d == WD_LIMIT) timeout_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      char_valid_q <= 1'b0;
      char_data_q  <= '0;
      char_core_q  <= '0;
      rr_q         <= '0;
      term_mask_q  <= '0;
      overflow_q   <= '0;
      exit_code_q  <= '0;
      all_done_q   <= 1'b0;
      timeout_q    <= 1'b0;
      wd_q         <= '0;
      for (int i = 0; i < NUM_CORES; i++) begin
        wr_ptr_q[i] <= '0;
        rd_ptr_q[i] <= '0;
      end
    end else begin
      char_valid_q <= char_valid_d;
      char_data_q  <= char_data_d;
      char_core_q  <= char_core_d;
      rr_q         <= rr_d;
      term_mask_q  <= term_mask_d;
      overflow_q   <= overflow_d;
      exit_code_q  <= exit_code_d;
      all_done_q   <= all_done_d;
      timeout_q    <= timeout_d;
      wd_q         <= wd_d;
      for (int i = 0; i < NUM_CORES; i++) begin
        wr_ptr_q[i] <= wr_ptr_d[i];
        rd_ptr_q[i] <= rd_ptr_d[i];
      end
    end
  end

  // Character storage needs no reset; validity lives entirely in the pointers.
  always_ff @(posedge clk) begin
    for (int i = 0; i < NUM_CORES; i++) begin
      if (push[i]) mem_q[i][wr_ptr_q[i][AW-1:0]] <= trace_r3[32*i +: 8];
    end
  end

  assign char_valid = char_valid_q;
  assign char_data  = char_data_q;
  assign char_core  = char_core_q;
  assign term_mask  = term_mask_q;
  assign exit_code  = exit_code_q;
  assign all_done   = all_done_q;
  assign timeout    = timeout_q;
  assign overflow   = overflow_q;

endmodule

// File: tb/tb_trace_event_collector.sv
// tb/tb_trace_event_collector.sv - scoreboard bench for trace_event_collector (9-core and 2-core instances)
module tb_trace_event_collector;

  localparam logic [31:0] PUTC = 32'h1500_0004;
  localparam logic [31:0] TERM = 32'h1500_0001;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n = 1'b0;

  logic [8:0]   a_valid;
  logic [287:0] a_insn, a_r3;
  logic         a_ready, a_cvalid, a_done, a_tmo;
  logic [7:0]   a_cdata;
  logic [3:0]   a_ccore;
  logic [8:0]   a_term, a_ovf;
  logic [287:0] a_exit;

  logic [1:0]   b_valid;
  logic [63:0]  b_insn, b_r3;
  logic         b_ready, b_cvalid, b_done, b_tmo;
  logic [7:0]   b_cdata;
  logic [0:0]   b_ccore;
  logic [1:0]   b_term, b_ovf;
  logic [63:0]  b_exit;

  trace_event_collector #(.NUM_CORES(9), .FIFO_DEPTH(8), .TIMEOUT_CYCLES(100)) dut_a (
    .clk(clk), .rst_n(rst_n), .trace_valid(a_valid), .trace_insn(a_insn), .trace_r3(a_r3),
    .char_valid(a_cvalid), .char_ready(a_ready), .char_data(a_cdata), .char_core(a_ccore),
    .term_mask(a_term), .exit_code(a_exit), .all_done(a_done), .timeout(a_tmo), .overflow(a_ovf)
  );

  trace_event_collector #(.NUM_CORES(2), .FIFO_DEPTH(4), .TIMEOUT_CYCLES(0)) dut_b (
    .clk(clk), .rst_n(rst_n), .trace_valid(b_valid), .trace_insn(b_insn), .trace_r3(b_r3),
    .char_valid(b_cvalid), .char_ready(b_ready), .char_data(b_cdata), .char_core(b_ccore),
    .term_mask(b_term), .exit_code(b_exit), .all_done(b_done), .timeout(b_tmo), .overflow(b_ovf)
  );

  int total = 0;
  int bad   = 0;
  logic [11:0] sb_a[$];
  logic [11:0] sb_b[$];
  logic [11:0] exp_c;

  task automatic drive_a(input int c, input logic [31:0] insn, input logic [31:0] r3);
    a_valid[c] = 1'b1;
    a_insn[32*c +: 32] = insn;
    a_r3[32*c +: 32] = r3;
  endtask

  task automatic idle_a();
    a_valid = '0; a_insn = '0; a_r3 = '0;
  endtask

  task automatic drive_b(input int c, input logic [31:0] insn, input logic [31:0] r3);
    b_valid[c] = 1'b1;
    b_insn[32*c +: 32] = insn;
    b_r3[32*c +: 32] = r3;
  endtask

  task automatic idle_b();
    b_valid = '0; b_insn = '0; b_r3 = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; a_ready = 1'b1; b_ready = 1'b1;
    idle_a(); idle_b();
    repeat (3) @(negedge clk);
    total++;
    if ({a_cvalid, a_cdata, a_ccore, a_term, a_done, a_tmo, a_ovf} !== '0 || a_exit !== '0) begin
      bad++;
      $display("FAIL reset_a: valid=%b data=%h core=%h term=%h done=%b tmo=%b ovf=%h exit=%h, required all 0",
               a_cvalid, a_cdata, a_ccore, a_term, a_done, a_tmo, a_ovf, a_exit);
    end
    total++;
    if ({b_cvalid, b_cdata, b_ccore, b_term, b_done, b_tmo, b_ovf} !== '0 || b_exit !== '0) begin
      bad++;
      $display("FAIL reset_b: valid=%b data=%h core=%h term=%h done=%b tmo=%b ovf=%h exit=%h, required all 0",
               b_cvalid, b_cdata, b_ccore, b_term, b_done, b_tmo, b_ovf, b_exit);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_timeout();
    repeat (99) @(negedge clk);
    total++;
    if (a_tmo !== 1'b0) begin bad++; $display("FAIL timeout_early: got %b after 99 edges, required 0", a_tmo); end
    @(negedge clk);
    total++;
    if (a_tmo !== 1'b1) begin bad++; $display("FAIL timeout_at_limit: got %b after 100 edges, required 1", a_tmo); end
    repeat (50) @(negedge clk);
    total++;
    if (b_tmo !== 1'b0) begin bad++; $display("FAIL timeout_disabled: got %b, required 0", b_tmo); end
  endtask

  task automatic test_single_putc();
    a_ready = 1'b1;
    drive_a(2, PUTC, 32'h41);
    sb_a.push_back({4'd2, 8'h41});
    @(negedge clk); idle_a();
    total++;
    if (a_cvalid !== 1'b0) begin bad++; $display("FAIL putc_not_yet: char_valid=%b, required 0", a_cvalid); end
    @(negedge clk);
    exp_c = sb_a.pop_front();
    total++;
    if ({a_cvalid, a_ccore, a_cdata} !== {1'b1, exp_c})
      begin bad++; $display("FAIL putc_one_cycle: got v=%b core=%0d data=%h, required v=1 core=%0d data=%h",
                             a_cvalid, a_ccore, a_cdata, exp_c[11:8], exp_c[7:0]); end
    @(negedge clk);
    total++;
    if (a_cvalid !== 1'b0) begin bad++; $display("FAIL putc_single_beat: char_valid=%b, required 0", a_cvalid); end
  endtask

  task automatic test_same_cycle();
    for (int c = 0; c < 3; c++) begin
      drive_a(c, PUTC, 32'h30 + 32'(c));
      sb_a.push_back({4'(c), 8'h30 + 8'(c)});
    end
    @(negedge clk); idle_a();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      exp_c = sb_a.pop_front();
      total++;
      if ({a_cvalid, a_ccore, a_cdata} !== {1'b1, exp_c})
        begin bad++; $display("FAIL same_cycle_%0d: got v=%b core=%0d data=%h, required v=1 core=%0d data=%h",
                               k, a_cvalid, a_ccore, a_cdata, exp_c[11:8], exp_c[7:0]); end
    end
    @(negedge clk);
    total++;
    if (a_cvalid !== 1'b0) begin bad++; $display("FAIL same_cycle_end: char_valid=%b, required 0", a_cvalid); end
  endtask

  task automatic test_backpressure();
    int n;
    a_ready = 1'b0;
    drive_a(4, PUTC, 32'h10);
    sb_a.push_back({4'd4, 8'h10});
    @(negedge clk); idle_a(); drive_a(4, PUTC, 32'h11);
    @(negedge clk); idle_a();
    for (int k = 0; k < 3; k++) begin
      total++;
      if ({a_cvalid, a_ccore, a_cdata} !== {1'b1, 4'd4, 8'h10})
        begin bad++; $display("FAIL hold_stable_%0d: got v=%b core=%0d data=%h, required v=1 core=4 data=10",
                               k, a_cvalid, a_ccore, a_cdata); end
      @(negedge clk);
    end
    drive_a(7, PUTC, 32'h61); drive_a(3, PUTC, 32'h63);
    @(negedge clk); idle_a();
    drive_a(7, PUTC, 32'h62); drive_a(3, PUTC, 32'h64);
    @(negedge clk); idle_a();
    sb_a.push_back({4'd7, 8'h61}); sb_a.push_back({4'd3, 8'h63}); sb_a.push_back({4'd4, 8'h11});
    sb_a.push_back({4'd7, 8'h62}); sb_a.push_back({4'd3, 8'h64});
    a_ready = 1'b1;
    n = 0;
    while (sb_a.size() > 0 && n < 40) begin
      if (a_cvalid === 1'b1) begin
        exp_c = sb_a.pop_front();
        total++;
        if ({a_ccore, a_cdata} !== exp_c)
          begin bad++; $display("FAIL rr_order: got core=%0d data=%h, required core=%0d data=%h",
                                 a_ccore, a_cdata, exp_c[11:8], exp_c[7:0]); end
      end
      @(negedge clk);
      n++;
    end
    total++;
    if (sb_a.size() != 0) begin bad++; $display("FAIL rr_drain: %0d chars missing, required 0", sb_a.size()); sb_a.delete(); end
    total++;
    if (n != 6) begin bad++; $display("FAIL rr_rate: drained in %0d cycles, required 6", n); end
    total++;
    if (a_cvalid !== 1'b0) begin bad++; $display("FAIL rr_end: char_valid=%b, required 0", a_cvalid); end
  endtask

  task automatic test_overflow();
    int n;
    b_ready = 1'b0;
    drive_b(1, PUTC, 32'h50);
    sb_b.push_back({4'd1, 8'h50});
    for (int k = 0; k < 4; k++) begin
      @(negedge clk); idle_b();
      drive_b(0, PUTC, 32'h30 + 32'(k));
      sb_b.push_back({4'd0, 8'h30 + 8'(k)});
    end
    @(negedge clk); idle_b();
    b_ready = 1'b1;
    drive_b(0, PUTC, 32'h34);
    sb_b.push_back({4'd0, 8'h34});
    n = 0;
    while (sb_b.size() > 0 && n < 40) begin
      if (b_cvalid === 1'b1) begin
        exp_c = sb_b.pop_front();
        total++;
        if ({3'b000, b_ccore, b_cdata} !== exp_c)
          begin bad++; $display("FAIL pushpop_order: got core=%0d data=%h, required core=%0d data=%h",
                                 b_ccore, b_cdata, exp_c[11:8], exp_c[7:0]); end
      end
      @(negedge clk); idle_b();
      n++;
    end
    total++;
    if (sb_b.size() != 0) begin bad++; $display("FAIL pushpop_drain: %0d chars missing, required 0", sb_b.size()); sb_b.delete(); end
    total++;
    if (b_ovf !== 2'b00) begin bad++; $display("FAIL pushpop_full: overflow=%b, required 00", b_ovf); end

    b_ready = 1'b0;
    drive_b(0, PUTC, 32'h40);
    sb_b.push_back({4'd0, 8'h40});
    for (int k = 0; k < 5; k++) begin
      @(negedge clk); idle_b();
      if (k == 4) begin
        total++;
        if (b_ovf !== 2'b00) begin bad++; $display("FAIL ovf_boundary: overflow=%b with FIFO just full, required 00", b_ovf); end
      end
      drive_b(1, PUTC, 32'h61 + 32'(k));
      if (k < 4) sb_b.push_back({4'd1, 8'h61 + 8'(k)});
    end
    @(negedge clk); idle_b();
    total++;
    if (b_ovf !== 2'b10) begin bad++; $display("FAIL ovf_set: overflow=%b, required 10", b_ovf); end
    b_ready = 1'b1;
    n = 0;
    while (sb_b.size() > 0 && n < 40) begin
      if (b_cvalid === 1'b1) begin
        exp_c = sb_b.pop_front();
        total++;
        if ({3'b000, b_ccore, b_cdata} !== exp_c)
          begin bad++; $display("FAIL ovf_order: got core=%0d data=%h, required core=%0d data=%h",
                                 b_ccore, b_cdata, exp_c[11:8], exp_c[7:0]); end
      end
      @(negedge clk);
      n++;
    end
    total++;
    if (sb_b.size() != 0) begin bad++; $display("FAIL ovf_drain: %0d chars missing, required 0", sb_b.size()); sb_b.delete(); end
    total++;
    if (b_cvalid !== 1'b0) begin bad++; $display("FAIL ovf_dropped_emitted: char_valid=%b data=%h, required 0", b_cvalid, b_cdata); end
  endtask

  task automatic test_termination();
    for (int i = 0; i < 9; i++) begin
      drive_a(i, TERM, 32'(i));
      @(negedge clk); idle_a();
      total++;
      if (a_term !== 9'((1 << (i + 1)) - 1))
        begin bad++; $display("FAIL term_mask_%0d: got %h, required %h", i, a_term, 9'((1 << (i + 1)) - 1)); end
      total++;
      if (a_done !== 1'b0) begin bad++; $display("FAIL done_early_%0d: all_done=%b, required 0", i, a_done); end
    end
    @(negedge clk);
    total++;
    if (a_done !== 1'b1) begin bad++; $display("FAIL done_set: all_done=%b, required 1", a_done); end
    for (int i = 0; i < 9; i++) begin
      total++;
      if (a_exit[32*i +: 32] !== 32'(i))
        begin bad++; $display("FAIL exit_code_%0d: got %h, required %h", i, a_exit[32*i +: 32], 32'(i)); end
    end
    drive_a(3, PUTC, 32'h55);
    drive_a(5, TERM, 32'hdead_beef);
    @(negedge clk); idle_a();
    @(negedge clk);
    total++;
    if (a_cvalid !== 1'b0 || a_exit[32*5 +: 32] !== 32'd5 || a_done !== 1'b1)
      begin bad++; $display("FAIL ignore_after_term: valid=%b exit5=%h done=%b, required 0 00000005 1",
                             a_cvalid, a_exit[32*5 +: 32], a_done); end
  endtask

  task automatic test_reset_mid();
    b_ready = 1'b0;
    drive_b(0, PUTC, 32'h71);
    @(negedge clk); idle_b(); drive_b(0, PUTC, 32'h72);
    @(negedge clk); idle_b(); drive_b(0, PUTC, 32'h73);
    @(negedge clk); idle_b();
    @(negedge clk);
    total++;
    if (b_cvalid !== 1'b1) begin bad++; $display("FAIL rst_mid_queued: char_valid=%b, required 1", b_cvalid); end
    rst_n = 1'b0;
    #1;
    total++;
    if ({b_cvalid, b_cdata, b_ccore, b_term, b_done, b_tmo, b_ovf} !== '0 || b_exit !== '0)
      begin bad++; $display("FAIL rst_mid_b: valid=%b data=%h core=%h term=%h done=%b ovf=%h, required all 0",
                             b_cvalid, b_cdata, b_ccore, b_term, b_done, b_ovf); end
    total++;
    if ({a_cvalid, a_term, a_done, a_tmo, a_ovf} !== '0 || a_exit !== '0)
      begin bad++; $display("FAIL rst_mid_a: valid=%b term=%h done=%b tmo=%b ovf=%h, required all 0",
                             a_cvalid, a_term, a_done, a_tmo, a_ovf); end
    @(negedge clk);
    rst_n = 1'b1;
    b_ready = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      total++;
      if (b_cvalid !== 1'b0) begin bad++; $display("FAIL rst_mid_stale_%0d: char_valid=%b data=%h, required 0", k, b_cvalid, b_cdata); end
    end
    drive_b(1, PUTC, 32'h7a);
    sb_b.push_back({4'd1, 8'h7a});
    @(negedge clk); idle_b();
    @(negedge clk);
    exp_c = sb_b.pop_front();
    total++;
    if ({b_cvalid, 3'b000, b_ccore, b_cdata} !== {1'b1, exp_c})
      begin bad++; $display("FAIL rst_mid_resume: got v=%b core=%0d data=%h, required v=1 core=%0d data=%h",
                             b_cvalid, b_ccore, b_cdata, exp_c[11:8], exp_c[7:0]); end
  endtask

  initial begin
    #100000;
    $display("FAIL global_timeout: bench still running at %0t, required completion", $time);
    $fatal(1, "bench stuck");
  end

  initial begin
    test_reset();
    test_timeout();
    test_single_putc();
    test_same_cycle();
    test_backpressure();
    test_overflow();
    test_termination();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
